vpg_mode_sel: RTL

//  Parametrised video-mode selector for the VPG. Debounces next/prev buttons,

---
 rtl/vpg_mode_sel.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vpg_mode_sel.sv
// vpg_mode_sel: video-mode selector for the VPG.
// Debounces next/prev buttons, honours a direct mode load, steps the mode
// index over [MODE_MIN..MODE_MAX], pulses vpg_mode_change on each accepted
// change, then holds off further changes until change_ack or a timeout.
// All state except the button synchronisers advances only on clk_en.

module vpg_mode_sel #(
   parameter int MODE_W         = 4,
   parameter int MODE_MIN       = 0,
   parameter int MODE_MAX       = 9,
   parameter int MODE_INIT      = 0,
   parameter bit WRAP           = 1'b1,
   parameter int DEBOUNCE_TICKS = 16,
   parameter int STARTUP_TICKS  = 9,
   parameter int ACK_TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              btn_next,
   input  logic              btn_prev,
   input  logic              mode_load,
   input  logic [MODE_W-1:0] mode_load_val,
   input  logic              mode_lock,
   input  logic              change_ack,
   output logic [MODE_W-1:0] vpg_mode,
   output logic              vpg_mode_change,
   output logic              mode_busy,
   output logic              ack_timeout
);

   localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam int ST_W = $clog2(STARTUP_TICKS + 1);
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
   localparam logic [ST_W-1:0]   ST_LAST = ST_W'(STARTUP_TICKS - 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [MODE_W-1:0] MIN_V   = MODE_W'(MODE_MIN);
   localparam logic [MODE_W-1:0] MAX_V   = MODE_W'(MODE_MAX);
   localparam logic [MODE_W-1:0] INIT_V  = MODE_W'(MODE_INIT);

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_IDLE,
      ST_PULSE,
      ST_WAIT
   } state_t;

   // Bit 0 is the next button, bit 1 the prev button.
   logic [1:0]           sync1_q, sync2_q;
   logic [1:0]           level_q, level_d;
   logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]           press;

   state_t              state_q;
   logic [MODE_W-1:0]   mode_q;
   logic                change_q, busy_q, timeout_q;
   logic [ST_W-1:0]     st_cnt_q;
   logic [TO_W-1:0]     to_cnt_q;

   logic                load_ok, step_next, step_prev;
   logic                evt;
   logic [MODE_W-1:0]   evt_mode;

   // Two-flop synchronisers run on every clk so the raw buttons are safe to sample.
   // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {btn_prev, btn_next};
         sync2_q <= sync1_q;
      end
   end

   // Debounce: flip the level after DEBOUNCE_TICKS consecutive differing ticks; a 0->1 flip is a press.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (which would infer a latch).
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      press    = '0;
      for (int i = 0; i < 2; i++) begin
         if (clk_en) begin
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               db_cnt_d[i] = '0;
               level_d[i]  = sync2_q[i];
               press[i]    = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Debounced levels reset high so a button held through reset is not seen as a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q  <= 2'b11;
         db_cnt_q <= '0;
      end else begin
         level_q  <= level_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // Event arbitration: load beats next beats prev; simultaneous next+prev cancel out.
   always_comb begin
      load_ok   = mode_load && (int'(mode_load_val) >= MODE_MIN) &&
                  (int'(mode_load_val) <= MODE_MAX);
      step_next = press[0] && !press[1] && !mode_lock;
      step_prev = press[1] && !press[0] && !mode_lock;
      evt       = 1'b0;
      evt_mode  = mode_q;
      if (load_ok) begin
         evt      = 1'b1;
         evt_mode = mode_load_val;
      end else if (step_next) begin
         if (mode_q != MAX_V) begin
            evt      = 1'b1;
            evt_mode = mode_q + MODE_W'(1);
         end else if (WRAP) begin
            evt      = 1'b1;
            evt_mode = MIN_V;
         end
      end else if (step_prev) begin
         if (mode_q != MIN_V) begin
            evt      = 1'b1;
            evt_mode = mode_q - MODE_W'(1);
         end else if (WRAP) begin
            evt      = 1'b1;
            evt_mode = MAX_V;
         end
      end
   end

   // Change-control FSM with registered outputs; events outside IDLE are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_STARTUP;
         mode_q    <= INIT_V;
         change_q  <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         st_cnt_q  <= '0;
         to_cnt_q  <= '0;
      end else if (clk_en) begin
         case (state_q)
            ST_STARTUP: begin
               if (st_cnt_q == ST_LAST) begin
                  mode_q   <= INIT_V;
                  change_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_PULSE;
               end else begin
                  st_cnt_q <= st_cnt_q + ST_W'(1);
               end
            end
            ST_IDLE: begin
               if (evt) begin
                  mode_q   <= evt_mode;
                  change_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               change_q <= 1'b0;
               to_cnt_q <= '0;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (change_ack) begin
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (to_cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign vpg_mode        = mode_q;
   assign vpg_mode_change = change_q;
   assign mode_busy       = busy_q;
   assign ack_timeout     = timeout_q;

endmodule
